satd_row_sched: RTL

- Sequences one block of HEIGHT rows through the combinational difference + horizontal-Hadamard datapath (`block`) and accumulates the absolute-sum of the horizontal transform outputs into one per-block cost.
- Issues row read addresses to the ORG/CUR line buffer, which has a 1-cycle read latency, and samples the 8 hth results one cycle later.
- Two-stage pipelined abs/accumulate.
- Returns the block cost over a valid/ready handshake.

---
 rtl/satd_pkg.sv | 26 ++
 rtl/satd_abs_sum.sv | 48 ++++
 rtl/satd_row_sched.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/satd_pkg.sv
// Shared widths and state encoding for the SATD row scheduler and its helpers.
package satd_pkg;

  // Width of one signed horizontal-Hadamard output for pixel MSB index l.
  function automatic int hth_w(input int l);
    return l + 5;
  endfunction

  // Width of the unsigned absolute-sum of one row of eight outputs.
  function automatic int row_sum_w(input int l);
    return l + 7;
  endfunction

  // Width of the per-block cost accumulator.
  function automatic int sum_w(input int l);
    return l + 12;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/satd_abs_sum.sv
// Combinational absolute-value and 3-level adder tree over eight signed
// transform outputs. Shared by the horizontal and vertical cost stages.
module satd_abs_sum
  import satd_pkg::*;
#(
  parameter int LENGTH = 11
) (
  input  logic signed [hth_w(LENGTH)-1:0]     x [8],
  output logic        [row_sum_w(LENGTH)-1:0] row_sum
);

  localparam int HW = hth_w(LENGTH);
  localparam int AW = LENGTH + 4;
  localparam int RW = row_sum_w(LENGTH);

  logic [HW-1:0]   mag_full [8];
  logic [AW-1:0]   mag      [8];
  logic [AW:0]     lvl1     [4];
  logic [AW+1:0]   lvl2     [2];
  logic [AW+2:0]   lvl3;

  // Magnitudes: real transform outputs never exceed 2^(LENGTH+4)-1, so the
  // top bit of the full-width magnitude is always zero and is dropped.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (x[i][HW-1]) begin
        mag_full[i] = $unsigned(-x[i]);
      end else begin
        mag_full[i] = $unsigned(x[i]);
      end
      mag[i] = mag_full[i][AW-1:0];
    end
  end

  // Balanced adder tree, one extra bit per level so nothing can wrap.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl1[i] = {1'b0, mag[2*i]} + {1'b0, mag[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
    end
    lvl3 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

  assign row_sum = RW'(lvl3);

endmodule

// File: rtl/satd_row_sched.sv
// Walks one block of HEIGHT rows through the difference/horizontal-Hadamard
// datapath, accumulates the absolute sums into one block cost and returns it
// over a valid/ready handshake.
module satd_row_sched
  import satd_pkg::*;
#(
  parameter int LENGTH = 11,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             row_rd_en,
  output logic [$clog2(HEIGHT)-1:0]        row_addr,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_0,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_1,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_2,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_3,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_4,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_5,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_6,
  input  logic signed [hth_w(LENGTH)-1:0]  hth_7,
  output logic                             sum_valid,
  input  logic                             sum_ready,
  output logic [sum_w(LENGTH)-1:0]         sum
);

  localparam int HW = hth_w(LENGTH);
  localparam int RW = row_sum_w(LENGTH);
  localparam int SW = sum_w(LENGTH);
  localparam int CW = $clog2(HEIGHT);
  localparam logic [CW-1:0] LAST_ROW = CW'(HEIGHT - 1);

  state_t          state;
  state_t          next_state;
  logic            v1;
  logic            v2;
  logic [RW-1:0]   row_sum;
  logic [RW-1:0]   row_sum_comb;
  logic [SW-1:0]   acc;
  logic [SW-1:0]   acc_next;
  logic signed [HW-1:0] hth [8];

  assign hth[0] = hth_0;
  assign hth[1] = hth_1;
  assign hth[2] = hth_2;
  assign hth[3] = hth_3;
  assign hth[4] = hth_4;
  assign hth[5] = hth_5;
  assign hth[6] = hth_6;
  assign hth[7] = hth_7;

  satd_abs_sum #(
    .LENGTH (LENGTH)
  ) u_abs_sum (
    .x       (hth),
    .row_sum (row_sum_comb)
  );

  // Next-state logic; start only matters in IDLE, acceptance only in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (row_addr == LAST_ROW) begin
          next_state = DRAIN;
        end else begin
          next_state = RUN;
        end
      end
      DRAIN: begin
        // Once stage 1 is empty, the only in-flight row sits in stage 2 and
        // is folded into the final write on this same edge.
        if (!v1) begin
          next_state = DONE;
        end else begin
          next_state = DRAIN;
        end
      end
      DONE: begin
        if (sum_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Accumulator value after the current edge, including any stage-2 row.
  always_comb begin
    if (v2) begin
      acc_next = acc + SW'(row_sum);
    end else begin
      acc_next = acc;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      row_rd_en <= 1'b0;
      row_addr  <= '0;
      sum_valid <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != IDLE);
      row_rd_en <= (next_state == RUN);
      sum_valid <= (next_state == DONE);
      if (state == IDLE && start) begin
        row_addr <= '0;
      end else if (state == RUN && next_state == RUN) begin
        row_addr <= row_addr + CW'(1);
      end else begin
        row_addr <= row_addr;
      end
    end
  end

  // Two-stage abs/accumulate pipeline and the held block cost.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      row_sum <= '0;
      acc     <= '0;
      sum     <= '0;
    end else begin
      v1 <= row_rd_en;
      v2 <= v1;
      if (v1) begin
        row_sum <= row_sum_comb;
      end else begin
        row_sum <= row_sum;
      end
      if (state == IDLE && start) begin
        acc <= '0;
      end else begin
        acc <= acc_next;
      end
      if (state == DRAIN && next_state == DONE) begin
        sum <= acc_next;
      end else begin
        sum <= sum;
      end
    end
  end

endmodule
